branch_predict: RTL and testbench
=================================

BRANCH_PREDICT -- requirements
Module: branch_predict

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, operands and targets.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, branch history table entries; SHALL be a power of two, at least 2.
REQ-003 SHALL have parameter CNT_INIT, default 2'b01, reset value of every counter (weakly not-taken).
REQ-004 Clock and reset SHALL be exactly: CLK  in  1  single clock, rising edge; RES  in  1  reset, asynchronous, active-high.
REQ-005 HLT  in  1  pipeline halt; freezes all state updates.
REQ-006 FPC  in  XLEN  fetch-stage PC.
REQ-007 FSIMM  in  XLEN  fetch-stage branch offset.
REQ-008 FBCC  in  1  fetched instruction is a conditional branch.
REQ-009 PRED_TAKEN  out  1  prediction for the fetched branch.
REQ-010 PRED_PC  out  XLEN  next fetch PC.
REQ-011 FCT3  in  3  execute-stage funct3.
REQ-012 U1REG, U2REG  in  XLEN each  execute-stage operands.
REQ-013 PC, SIMM, DADDR  in  XLEN each  execute PC, offset, JALR target.
REQ-014 JAL, JALR, BCC  in  1 each  execute-stage instruction class.
REQ-015 PTAKEN  in  1  prediction carried down the pipe with the executing branch.
REQ-016 JREQ  out  1  redirect fetch.
REQ-017 JVAL  out  XLEN  redirect target.
REQ-018 NBR, NMISS  out  XLEN each  retired-branch and mispredict counters.

Function
REQ-019 Index SHALL be PC[log2(BHT_DEPTH)+1:2], for both the fetch read and the execute update.
REQ-020 PRED_TAKEN SHALL be FBCC AND bit 1 of the counter at the fetch index; it is a combinational read of registered state.
REQ-021 PRED_PC SHALL be FPC+FSIMM when PRED_TAKEN=1, else FPC+4, modulo 2^XLEN.
REQ-022 Branch outcome BMUX SHALL be:
  - FCT3=0: U1==U2
  - FCT3=1: U1!=U2
  - FCT3=4: signed U1<U2
  - FCT3=5: signed U1>=U2
  - FCT3=6: unsigned U1<U2
  - FCT3=7: unsigned U1>=U2
  - FCT3=2 or 3: 0
REQ-023 Signed compares SHALL be internal (two's complement at XLEN); there are no separate signed or duplicated operand inputs.
REQ-024 JREQ SHALL be JAL OR JALR OR (BCC AND (BMUX XOR PTAKEN)), combinational.
REQ-025 JVAL SHALL be:
  - DADDR when JALR
  - PC+4 when BCC AND NOT BMUX
  - PC+SIMM otherwise
REQ-026 At a rising CLK with BCC=1 and HLT=0, the counter at the execute index SHALL move +1 if BMUX, -1 otherwise, saturating at 2'b00 and 2'b11.
REQ-027 Counter states SHALL be SNT=00, WNT=01, WT=10, ST=11.
REQ-028 Same-cycle fetch read and update of one index: the read SHALL return the pre-update value (no bypass).
REQ-029 At a rising CLK with BCC=1 and HLT=0, NBR SHALL increment by 1, and NMISS SHALL increment by 1 if BMUX!=PTAKEN.
REQ-030 NBR and NMISS SHALL saturate at all-ones.
REQ-031 JAL and JALR SHALL NOT update the table or either counter.
REQ-032 HLT=1 SHALL hold all state; combinational outputs remain valid.

Reset
REQ-033 RES=1 SHALL immediately (asynchronously) set every counter to CNT_INIT and NBR=NMISS=0.
REQ-034 During and after reset, with default CNT_INIT, PRED_TAKEN SHALL be 0 and PRED_PC SHALL be FPC+4.
REQ-035 Reset asserted mid-update SHALL win; no partial update SHALL survive.

Structure
REQ-036 Package branch_pkg SHALL hold the funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the 2-bit counter state enum.
REQ-037 One combinational sub-module, branch_cmp (FCT3, operands, XLEN -> BMUX), SHALL be instantiated.
REQ-038 The counter table SHALL be a flop array (no RAM macro), so that reset is asynchronous.

Verification
REQ-039 Reset, then FBCC=1, FPC=0x100, FSIMM=0x20 -> PRED_TAKEN=0, PRED_PC=0x104; NBR=NMISS=0.
REQ-040 Two BEQ at PC=0x100, U1=U2=5, PTAKEN=0 -> both cycles JREQ=1, JVAL=PC+SIMM; counter[0] 01->10->11; third fetch at 0x100 predicts taken; NMISS=2.
REQ-041 BLT U1=0xFFFFFFFF, U2=1 -> taken; BLTU with same operands -> not taken; with PTAKEN=1 the BLTU case gives JREQ=1, JVAL=PC+4.
REQ-042 Counter at ST with four not-taken updates -> 11,10,01,00,00 (saturates); HLT=1 during one update -> no change that cycle.
REQ-043 JALR DADDR=0x2000 -> JREQ=1, JVAL=0x2000, NBR unchanged; FCT3=2 with BCC=1 and PTAKEN=0 -> JREQ=0.
REQ-044 RES asserted between clock edges with a pending update -> counters read CNT_INIT before the next edge; same-index read/update returns the old value.

Source files
------------

// File: rtl/branch_predict_pkg.sv
// Shared definitions for the branch predictor: funct3 branch encodings and the
// 2-bit saturating counter states with their update rule.
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'd0;
    localparam logic [2:0] BNE  = 3'd1;
    localparam logic [2:0] BLT  = 3'd4;
    localparam logic [2:0] BGE  = 3'd5;
    localparam logic [2:0] BLTU = 3'd6;
    localparam logic [2:0] BGEU = 3'd7;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Saturating step toward taken (+1) or not-taken (-1).
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e r;
        r = c;
        if (taken) begin
            if (c != ST) r = ctr_e'(2'(c + 2'd1));
        end else begin
            if (c != SNT) r = ctr_e'(2'(c - 2'd1));
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predict_if.sv
// Fetch/execute-side signal bundle of the branch predictor.
// There is no handshake: every output is a combinational function of the current
// inputs and registered state, and HLT is the only flow control (it freezes updates).
interface branch_predict_if #(
    parameter int XLEN = 32
);
    logic            HLT;
    logic [XLEN-1:0] FPC;
    logic [XLEN-1:0] FSIMM;
    logic            FBCC;
    logic            PRED_TAKEN;
    logic [XLEN-1:0] PRED_PC;
    logic [2:0]      FCT3;
    logic [XLEN-1:0] U1REG;
    logic [XLEN-1:0] U2REG;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] SIMM;
    logic [XLEN-1:0] DADDR;
    logic            JAL;
    logic            JALR;
    logic            BCC;
    logic            PTAKEN;
    logic            JREQ;
    logic [XLEN-1:0] JVAL;
    logic [XLEN-1:0] NBR;
    logic [XLEN-1:0] NMISS;

    modport master (
        output HLT, FPC, FSIMM, FBCC, FCT3, U1REG, U2REG, PC, SIMM, DADDR,
               JAL, JALR, BCC, PTAKEN,
        input  PRED_TAKEN, PRED_PC, JREQ, JVAL, NBR, NMISS
    );

    modport slave (
        input  HLT, FPC, FSIMM, FBCC, FCT3, U1REG, U2REG, PC, SIMM, DADDR,
               JAL, JALR, BCC, PTAKEN,
        output PRED_TAKEN, PRED_PC, JREQ, JVAL, NBR, NMISS
    );

endinterface

// File: rtl/branch_cmp.sv
// Branch condition evaluator: resolves funct3 against two operands.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      fct3,
    input  logic [XLEN-1:0] u1,
    input  logic [XLEN-1:0] u2,
    output logic            bmux
);

    always_comb begin
        bmux = 1'b0;
        case (fct3)
            BEQ:     bmux = (u1 == u2);
            BNE:     bmux = (u1 != u2);
            BLT:     bmux = ($signed(u1) <  $signed(u2));
            BGE:     bmux = ($signed(u1) >= $signed(u2));
            BLTU:    bmux = (u1 <  u2);
            BGEU:    bmux = (u1 >= u2);
            default: bmux = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict.sv
// Bimodal branch predictor: 2-bit counter table read at fetch, trained at execute,
// plus redirect generation and retired-branch / mispredict statistics.
module branch_predict
    import branch_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input logic             CLK,
    input logic             RES,
    branch_predict_if.slave bp
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] x_idx;
    logic [1:0]       f_cnt;
    logic             bmux;
    logic             upd;
    logic             miss;

    ctr_e            cnt_q [BHT_DEPTH];
    ctr_e            cnt_d [BHT_DEPTH];
    logic [XLEN-1:0] nbr_q, nbr_d;
    logic [XLEN-1:0] nmiss_q, nmiss_d;

    assign f_idx = bp.FPC[IDX_W+1:2];
    assign x_idx = bp.PC[IDX_W+1:2];

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .fct3 (bp.FCT3),
        .u1   (bp.U1REG),
        .u2   (bp.U2REG),
        .bmux (bmux)
    );

    // Fetch side reads registered counters only, so a same-cycle update is not visible.
    always_comb begin
        f_cnt         = cnt_q[f_idx];
        bp.PRED_TAKEN = bp.FBCC & f_cnt[1];
        bp.PRED_PC    = bp.PRED_TAKEN ? (bp.FPC + bp.FSIMM) : (bp.FPC + XLEN'(4));
    end

    always_comb begin
        bp.JREQ = bp.JAL | bp.JALR | (bp.BCC & (bmux ^ bp.PTAKEN));
        if (bp.JALR)
            bp.JVAL = bp.DADDR;
        else if (bp.BCC && !bmux)
            bp.JVAL = bp.PC + XLEN'(4);
        else
            bp.JVAL = bp.PC + bp.SIMM;
        bp.NBR   = nbr_q;
        bp.NMISS = nmiss_q;
    end

    assign upd  = bp.BCC & ~bp.HLT;
    assign miss = bmux ^ bp.PTAKEN;

    always_comb begin
        cnt_d   = cnt_q;
        nbr_d   = nbr_q;
        nmiss_d = nmiss_q;
        if (upd) begin
            cnt_d[x_idx] = ctr_next(cnt_q[x_idx], bmux);
            if (nbr_q != '1) nbr_d = nbr_q + XLEN'(1);
            if (miss && nmiss_q != '1) nmiss_d = nmiss_q + XLEN'(1);
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= ctr_e'(CNT_INIT);
            nbr_q   <= '0;
            nmiss_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            nbr_q   <= nbr_d;
            nmiss_q <= nmiss_d;
        end
    end

endmodule

// File: tb/tb_branch_predict.sv
// Directed bench for branch_predict: the driver pushes expected values per vector,
// a negedge monitor pops and compares them against the DUT.
module tb_branch_predict;
    import branch_pkg::*;

    logic CLK = 1'b0;
    logic RES;

    branch_predict_if #(.XLEN(32)) bp ();

    branch_predict #(.XLEN(32), .BHT_DEPTH(16), .CNT_INIT(2'b01)) dut (
        .CLK (CLK),
        .RES (RES),
        .bp  (bp.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam int S_PT = 0, S_PPC = 1, S_JREQ = 2, S_JVAL = 3;
    localparam int S_NBR = 4, S_NMISS = 5, S_CNT0 = 6, S_CNT1 = 7;

    function automatic logic [31:0] act(input int sel);
        case (sel)
            S_PT:    return {31'd0, bp.PRED_TAKEN};
            S_PPC:   return bp.PRED_PC;
            S_JREQ:  return {31'd0, bp.JREQ};
            S_JVAL:  return bp.JVAL;
            S_NBR:   return bp.NBR;
            S_NMISS: return bp.NMISS;
            S_CNT0:  return {30'd0, dut.cnt_q[0]};
            S_CNT1:  return {30'd0, dut.cnt_q[1]};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string n, input int s, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        exp_q.push_back(c);
    endtask

    // Monitor: outputs are combinational, so they are sampled mid-cycle.
    always @(negedge CLK) begin
        chk_t        c;
        logic [31:0] a;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            a = act(c.sel);
            n_total++;
            if (a === c.exp) n_pass++;
            else $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, a, c.exp);
        end
    end

    task automatic idle();
        bp.HLT    = 1'b0;
        bp.BCC    = 1'b0;
        bp.JAL    = 1'b0;
        bp.JALR   = 1'b0;
        bp.PTAKEN = 1'b0;
        bp.FCT3   = 3'd0;
        bp.U1REG  = '0;
        bp.U2REG  = '0;
        bp.PC     = '0;
        bp.SIMM   = '0;
        bp.DADDR  = '0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic [31:0] u1, input logic [31:0] u2,
                          input logic [31:0] pc, input logic [31:0] simm, input logic pt);
        idle();
        bp.BCC    = 1'b1;
        bp.FCT3   = f3;
        bp.U1REG  = u1;
        bp.U2REG  = u2;
        bp.PC     = pc;
        bp.SIMM   = simm;
        bp.PTAKEN = pt;
    endtask

    task automatic cycle();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RES = 1'b1;
        idle();
        bp.FBCC  = 1'b1;
        bp.FPC   = 32'h100;
        bp.FSIMM = 32'h20;
        #2;
        push("rst_pred_taken", S_PT, 0);
        push("rst_pred_pc", S_PPC, 32'h104);
        push("rst_nbr", S_NBR, 0);
        push("rst_nmiss", S_NMISS, 0);
        push("rst_cnt0", S_CNT0, 2'b01);
        @(negedge CLK);
        #1;
        RES = 1'b0;
        push("post_rst_pred_taken", S_PT, 0);
        push("post_rst_pred_pc", S_PPC, 32'h104);
        @(posedge CLK);
        #1;

        // Two correctly-taken BEQs predicted not-taken: both mispredict.
        branch(BEQ, 5, 5, 32'h100, 32'h40, 1'b0);
        push("beq1_jreq", S_JREQ, 1);
        push("beq1_jval", S_JVAL, 32'h140);
        push("beq1_pt", S_PT, 0);
        push("beq1_cnt0", S_CNT0, 2'b01);
        cycle();
        branch(BEQ, 5, 5, 32'h100, 32'h40, 1'b0);
        push("beq2_cnt0", S_CNT0, 2'b10);
        push("beq2_pt_old", S_PT, 1);
        push("beq2_ppc", S_PPC, 32'h120);
        push("beq2_jreq", S_JREQ, 1);
        push("beq2_jval", S_JVAL, 32'h140);
        push("beq2_nbr", S_NBR, 1);
        push("beq2_nmiss", S_NMISS, 1);
        cycle();
        idle();
        push("after_beq_cnt0", S_CNT0, 2'b11);
        push("third_fetch_pt", S_PT, 1);
        push("third_fetch_ppc", S_PPC, 32'h120);
        push("after_beq_nbr", S_NBR, 2);
        push("after_beq_nmiss", S_NMISS, 2);
        push("idle_jreq", S_JREQ, 0);
        cycle();

        // Signed vs unsigned compares on index 1.
        branch(BLT, 32'hFFFF_FFFF, 1, 32'h204, 32'h10, 1'b0);
        push("blt_jreq", S_JREQ, 1);
        push("blt_jval", S_JVAL, 32'h214);
        push("blt_cnt1", S_CNT1, 2'b01);
        cycle();
        branch(BLTU, 32'hFFFF_FFFF, 1, 32'h204, 32'h10, 1'b1);
        push("bltu_pt1_jreq", S_JREQ, 1);
        push("bltu_pt1_jval", S_JVAL, 32'h208);
        push("bltu_pt1_cnt1", S_CNT1, 2'b10);
        push("bltu_pt1_nbr", S_NBR, 3);
        push("bltu_pt1_nmiss", S_NMISS, 3);
        cycle();
        branch(BLTU, 32'hFFFF_FFFF, 1, 32'h204, 32'h10, 1'b0);
        push("bltu_pt0_jreq", S_JREQ, 0);
        push("bltu_pt0_cnt1", S_CNT1, 2'b01);
        push("bltu_pt0_nbr", S_NBR, 4);
        push("bltu_pt0_nmiss", S_NMISS, 4);
        cycle();
        branch(BGEU, 32'hFFFF_FFFF, 1, 32'h204, 32'h10, 1'b1);
        push("bgeu_jreq", S_JREQ, 0);
        push("bgeu_jval", S_JVAL, 32'h214);
        push("bgeu_cnt1", S_CNT1, 2'b00);
        cycle();

        // Walk index 0 down from ST with not-taken BNEs, one of them halted.
        branch(BNE, 7, 7, 32'h100, 32'h40, 1'b1);
        push("nt1_cnt0", S_CNT0, 2'b11);
        push("nt1_jreq", S_JREQ, 1);
        push("nt1_jval", S_JVAL, 32'h104);
        push("nt1_nbr", S_NBR, 6);
        push("nt1_nmiss", S_NMISS, 4);
        cycle();
        branch(BNE, 7, 7, 32'h100, 32'h40, 1'b1);
        bp.HLT = 1'b1;
        push("hlt_cnt0", S_CNT0, 2'b10);
        push("hlt_jreq", S_JREQ, 1);
        cycle();
        branch(BNE, 7, 7, 32'h100, 32'h40, 1'b1);
        push("post_hlt_cnt0", S_CNT0, 2'b10);
        push("post_hlt_nbr", S_NBR, 7);
        push("post_hlt_nmiss", S_NMISS, 5);
        cycle();
        branch(BNE, 7, 7, 32'h100, 32'h40, 1'b1);
        push("nt3_cnt0", S_CNT0, 2'b01);
        cycle();
        branch(BNE, 7, 7, 32'h100, 32'h40, 1'b1);
        push("nt4_cnt0", S_CNT0, 2'b00);
        cycle();

        // Jumps redirect but never train or count.
        idle();
        bp.JALR  = 1'b1;
        bp.DADDR = 32'h2000;
        bp.PC    = 32'h100;
        bp.SIMM  = 32'h40;
        push("jalr_jreq", S_JREQ, 1);
        push("jalr_jval", S_JVAL, 32'h2000);
        push("sat_low_cnt0", S_CNT0, 2'b00);
        push("jalr_nbr", S_NBR, 10);
        push("jalr_nmiss", S_NMISS, 8);
        cycle();
        idle();
        bp.JAL  = 1'b1;
        bp.PC   = 32'h300;
        bp.SIMM = 32'h8;
        push("jal_jreq", S_JREQ, 1);
        push("jal_jval", S_JVAL, 32'h308);
        push("jal_nbr", S_NBR, 10);
        cycle();
        branch(3'd2, 5, 5, 32'h100, 32'h40, 1'b0);
        push("f3_2_jreq", S_JREQ, 0);
        push("f3_2_jval", S_JVAL, 32'h104);
        push("f3_2_nbr", S_NBR, 10);
        push("f3_2_nmiss", S_NMISS, 8);
        push("f3_2_cnt0", S_CNT0, 2'b00);
        cycle();

        // Asynchronous reset between edges with an update pending.
        branch(BNE, 5, 5, 32'h100, 32'h40, 1'b0);
        #2;
        RES = 1'b1;
        push("async_rst_cnt0", S_CNT0, 2'b01);
        push("async_rst_nbr", S_NBR, 0);
        push("async_rst_nmiss", S_NMISS, 0);
        @(negedge CLK);
        #1;
        RES = 1'b0;
        idle();
        @(posedge CLK);
        #1;
        push("after_rst_cnt0", S_CNT0, 2'b01);
        push("after_rst_nbr", S_NBR, 0);
        cycle();

        // Same-index read during update sees the old counter.
        branch(BEQ, 5, 5, 32'h100, 32'h40, 1'b0);
        push("bypass_pt_old", S_PT, 0);
        push("bypass_ppc_old", S_PPC, 32'h104);
        cycle();
        idle();
        push("bypass_pt_new", S_PT, 1);
        push("bypass_ppc_new", S_PPC, 32'h120);
        push("bypass_nbr", S_NBR, 1);
        push("bypass_nmiss", S_NMISS, 1);
        cycle();

        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
            n_total++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
